// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared state type and sizing constants for mult_div_unit
// The DIV state exists only when MULT_DIV_DIV_EN is defined.
package mult_div_pkg;

  function automatic int iter_count(input int width);
    return width;
  endfunction

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = iter_count(MD_WIDTH);

`ifdef MULT_DIV_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} md_state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} md_state_e;
`endif

endpackage

// File: rtl/mult_div_if.sv
// rtl/mult_div_if.sv - operand, start and result bundle of mult_div_unit
// master drives operands/starts, slave (the unit) drives hi/lo and status.
interface mult_div_if #(
  parameter int WIDTH = mult_div_pkg::MD_WIDTH
);
  logic [WIDTH-1:0] entryA;
  logic [WIDTH-1:0] entryB;
  logic             multStart;
  logic             divStart;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             divZero;

  modport master (
    output entryA, entryB, multStart, divStart,
    input  hi, lo, busy, done, divZero
  );

  modport slave (
    input  entryA, entryB, multStart, divStart,
    output hi, lo, busy, done, divZero
  );
endinterface

// File: rtl/div_core.sv
// rtl/div_core.sv - signed restoring divider datapath, one quotient bit per step
// Works on magnitudes; quo/rem present the sign-corrected result of the step in flight.
module div_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  logic [WIDTH-1:0] rem_r, q_r, dvsr;
  logic [WIDTH-1:0] rem_nx, q_nx, diff;
  logic [WIDTH:0]   shifted;
  logic             neg_q, neg_r, ge;

  // Partial remainder never exceeds dvsr-1, so the trial difference fits WIDTH bits when taken.
  assign shifted = {rem_r, q_r[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvsr};
  assign diff    = shifted[WIDTH-1:0] - dvsr;
  assign rem_nx  = ge ? diff : shifted[WIDTH-1:0];
  assign q_nx    = {q_r[WIDTH-2:0], ge};
  assign quo     = neg_q ? -q_nx : q_nx;
  assign rem     = neg_r ? -rem_nx : rem_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r <= '0;
      q_r   <= '0;
      dvsr  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      rem_r <= '0;
      q_r   <= dividend[WIDTH-1] ? -dividend : dividend;
      dvsr  <= divisor[WIDTH-1] ? -divisor : divisor;
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end else if (step) begin
      rem_r <= rem_nx;
      q_r   <= q_nx;
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - signed radix-2 Booth multiplier plus optional divider (MULT_DIV_DIV_EN)
// hi/lo change only on the edge entering DONE; WIDTH steps per operation.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  mult_div_if.slave bus
);
  localparam int ITERS = iter_count(WIDTH);
  localparam int CW    = $clog2(ITERS + 1);

  md_state_e        state, state_nx;
  logic [CW-1:0]    cnt;
  logic             last_step, start_op, commit;
  logic             load_mult, commit_mult;
  logic [WIDTH-1:0] hi_r, lo_r, res_hi, res_lo;

  logic [WIDTH:0]   acc_hi, booth_sum, booth_hi_nx;
  logic [WIDTH-1:0] acc_lo, mcand, booth_lo_nx;
  logic             q_m1;

  // acc_hi carries one guard bit so subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = acc_hi + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = acc_hi - {mcand[WIDTH-1], mcand};
      default: booth_sum = acc_hi;
    endcase
  end

  assign booth_hi_nx = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_lo_nx = {booth_sum[0], acc_lo[WIDTH-1:1]};
  assign last_step   = (cnt == CW'(1));

`ifdef MULT_DIV_DIV_EN
  logic             load_div, commit_div, div_zero_nx, dz_r;
  logic [WIDTH-1:0] div_quo, div_rem;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load_div),
    .step     (state == S_DIV),
    .dividend (bus.entryA),
    .divisor  (bus.entryB),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  assign commit      = commit_mult | commit_div;
  assign start_op    = load_mult | load_div;
  assign res_hi      = commit_div ? div_rem : booth_hi_nx[WIDTH-1:0];
  assign res_lo      = commit_div ? div_quo : booth_lo_nx;
  assign bus.busy    = (state == S_MULT) || (state == S_DIV);
  assign bus.divZero = dz_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dz_r <= 1'b0;
    else       dz_r <= div_zero_nx;
  end
`else
  assign commit      = commit_mult;
  assign start_op    = load_mult;
  assign res_hi      = booth_hi_nx[WIDTH-1:0];
  assign res_lo      = booth_lo_nx;
  assign bus.busy    = (state == S_MULT);
  assign bus.divZero = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    load_mult   = 1'b0;
    commit_mult = 1'b0;
`ifdef MULT_DIV_DIV_EN
    load_div    = 1'b0;
    commit_div  = 1'b0;
    div_zero_nx = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (bus.multStart) begin
          state_nx  = S_MULT;
          load_mult = 1'b1;
        end
`ifdef MULT_DIV_DIV_EN
        else if (bus.divStart) begin
          if (bus.entryB == '0) begin
            state_nx    = S_DONE;
            div_zero_nx = 1'b1;
          end else begin
            state_nx = S_DIV;
            load_div = 1'b1;
          end
        end
`endif
      end
      S_MULT: if (last_step) begin
        state_nx    = S_DONE;
        commit_mult = 1'b1;
      end
`ifdef MULT_DIV_DIV_EN
      S_DIV: if (last_step) begin
        state_nx   = S_DONE;
        commit_div = 1'b1;
      end
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
      q_m1   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      state <= state_nx;
      if (start_op)      cnt <= CW'(ITERS);
      else if (bus.busy) cnt <= cnt - CW'(1);
      if (load_mult) begin
        acc_hi <= '0;
        acc_lo <= bus.entryB;
        mcand  <= bus.entryA;
        q_m1   <= 1'b0;
      end else if (state == S_MULT) begin
        acc_hi <= booth_hi_nx;
        acc_lo <= booth_lo_nx;
        q_m1   <= acc_lo[0];
      end
      if (commit) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.done = (state == S_DONE);
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized scoreboard bench for mult_div_unit
// Divide expectations apply only when MULT_DIV_DIV_EN is defined.
module tb_mult_div_unit;
  localparam int W     = 32;
  localparam int ITERS = 32;
`ifdef MULT_DIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         keep;
    logic         dz;
    int           done_cyc;
  } exp_t;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  int           cyc      = 0;
  int           checks   = 0;
  int           failures = 0;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    e = '0;
    if (m) begin
      p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.keep = 1'b1;
      e.dz   = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'd1;
      5:       v = W'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      model_hi = '0;
      model_lo = '0;
      check("reset_hi", bus.hi, 0);
      check("reset_lo", bus.lo, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_divzero", bus.divZero, 0);
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", bus.done, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.keep) begin
          mon_e.hi = model_hi;
          mon_e.lo = model_lo;
        end
        check("result_hi", bus.hi, mon_e.hi);
        check("result_lo", bus.lo, mon_e.lo);
        check("result_divzero", bus.divZero, mon_e.dz);
        check("done_cycle", cyc, mon_e.done_cyc);
        model_hi = mon_e.hi;
        model_lo = mon_e.lo;
      end
    end else begin
      check("hold_hi", bus.hi, model_hi);
      check("hold_lo", bus.lo, model_lo);
      check("idle_divzero", bus.divZero, 0);
    end
  end

  task automatic run_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input int spur_at);
    exp_t e;
    bit   acc;
    int   lat;
    @(posedge clk); #1;
    bus.multStart = m;
    bus.divStart  = d;
    bus.entryA    = a;
    bus.entryB    = b;
    acc = m || (DIV_EN && d);
    lat = 0;
    if (acc) begin
      e = model(m, a, b);
      lat = e.dz ? 1 : ITERS + 1;
      e.done_cyc = cyc + lat;
      exp_q.push_back(e);
    end
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clk); #1;
      if (!hold || k > lat) begin
        bus.multStart = 1'b0;
        bus.divStart  = 1'b0;
      end
      bus.entryA = $urandom;
      bus.entryB = $urandom;
      if (k == spur_at && k < lat) begin
        bus.multStart = 1'b1;
        bus.divStart  = 1'b1;
      end
      check("busy", bus.busy, (k < lat));
    end
    check("drained", exp_q.size(), 0);
    exp_q.delete();
    bus.multStart = 1'b0;
    bus.divStart  = 1'b0;
  endtask

  task automatic reset_mid_op();
    @(posedge clk); #1;
    bus.entryA = 32'hFFFF_FFF9;
    bus.entryB = 32'd2;
    if (DIV_EN) bus.divStart  = 1'b1;
    else        bus.multStart = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      bus.multStart = 1'b0;
      bus.divStart  = 1'b0;
    end
    check("busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_hi", bus.hi, 0);
    check("abort_lo", bus.lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.multStart = 1'b0;
    bus.divStart  = 1'b0;
    bus.entryA    = '0;
    bus.entryB    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 0);
    run_op(1'b1, 1'b1, 32'h0000_1234, 32'hFFFF_FFAB, 1'b0, 10);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    reset_mid_op();
    run_op(1'b1, 1'b0, 32'h0001_0001, 32'h0000_0101, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      logic         m, d;
      a = pick();
      b = pick();
      m = ($urandom_range(0, 2) == 0);
      d = 1'($urandom_range(0, 1));
      run_op(m, d, a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 34)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits.
REQ-002 The unit SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: entryA  input  WIDTH  operand A (multiplicand / dividend), from register A.
REQ-006 Port: entryB  input  WIDTH  operand B (multiplier / divisor), same register-B value that the ALU source-B mux receives as its entry 0.
REQ-007 Port: multStart  input  1  request a signed multiply; sampled only in IDLE.
REQ-008 Port: divStart  input  1  request a signed divide; sampled only in IDLE.
REQ-009 Port: hi  output  WIDTH  HI register.
REQ-010 Port: lo  output  WIDTH  LO register.
REQ-011 Port: busy  output  1  high in MULT and DIV states.
REQ-012 Port: done  output  1  one-cycle pulse: result committed.
REQ-013 Port: divZero  output  1  one-cycle pulse: divide by zero detected.

Function
REQ-014 FSM states SHALL be IDLE, MULT, DIV, DONE; transitions occur only on the rising edge of clk.
REQ-015 In IDLE, multStart=1 SHALL latch entryA/entryB and move to MULT; else divStart=1 SHALL latch operands and move to DIV; multStart wins if both are high.
REQ-016 multStart/divStart SHALL be ignored outside IDLE; in-flight operands do not change.
REQ-017 MULT SHALL run radix-2 Booth, one step per cycle, exactly WIDTH cycles, then go to DONE.
REQ-018 Product SHALL be the signed 2*WIDTH result: hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-019 DIV SHALL run signed restoring division, one bit per cycle, exactly WIDTH cycles, then go to DONE.
REQ-020 Quotient SHALL be truncated toward zero into lo; remainder SHALL take the dividend's sign and go into hi.
REQ-021 -2^(WIDTH-1) / -1 SHALL wrap: lo = 0x80000000, hi = 0.
REQ-022 entryB = 0 at divStart SHALL skip iterations: go to DONE on the next edge, pulse divZero with done, and leave hi/lo unchanged.
REQ-023 hi/lo SHALL update only on the edge entering DONE; they hold their value at all other times.
REQ-024 Latency SHALL be start edge + WIDTH + 1 edges until done is seen high (33 cycles for WIDTH=32); divide-by-zero latency is 1 edge.
REQ-025 DONE SHALL last one cycle, then return to IDLE; a start seen during DONE SHALL be ignored.

Reset
REQ-026 Asserting reset at any time, including mid-operation, SHALL force IDLE, hi=lo=0, busy=done=divZero=0, and clear all internal registers.
REQ-027 An operation aborted by reset SHALL produce no done pulse and no result.

Configuration
REQ-028 Macro MULT_DIV_DIV_EN: when defined, the DIV path is compiled in as specified above.
REQ-029 When MULT_DIV_DIV_EN is undefined, divStart SHALL be ignored, the DIV state and divider logic SHALL be absent, and divZero SHALL be tied to 0.

Structure
REQ-030 Shared package mult_div_pkg SHALL hold the state enum, the WIDTH default, and the iteration-count constant.
REQ-031 The divider datapath SHALL live in sub-module div_core, instantiated only under MULT_DIV_DIV_EN; the Booth datapath stays inline.

Verification
REQ-032 multStart, A=7, B=-3 -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 multStart, A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 divStart, A=-7, B=2 -> done at cycle 33; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-035 divStart, A=5, B=0 -> divZero and done on the next cycle; hi/lo keep their prior values (e.g. 0x11/0x22).
REQ-036 multStart and divStart both high -> multiply performed; a new start pulse at cycle 10 is ignored and busy stays 1 until DONE.
REQ-037 reset asserted at cycle 15 of a divide -> IDLE immediately, hi=lo=0, no done pulse; a following multiply completes normally.
